// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// ----------------
// Owns the single write port of the LED-matrix column RAM. Up to NREQ writer
// blocks share the port through round-robin burst grants. A built-in clear
// engine fills CLEAR_LEN words starting at CLEAR_BASE with CLEAR_DATA.
//
// Ports
//   clk, rst     : single clock; synchronous active-high reset
//   req[i]       : requester i wants the port; held high for the whole burst
//   gnt[i]       : one-hot registered grant, all zero when nobody owns the port
//   wr_en_in[i]  : write strobe from requester i
//   wr_addr_in   : flattened addresses, requester i at [i*AW +: AW]
//   wr_data_in   : flattened data, requester i at [i*DW +: DW]
//   clear_start  : one-cycle pulse requesting a clear
//   clear_busy   : clear engine owns the port
//   clear_done   : one-cycle pulse after the last clear write
//   mem_we/mem_addr/mem_data : registered RAM write port
//   conflict     : sticky; a non-granted requester strobed wr_en_in
//
// Handshake: a requester raises req and keeps it high; it owns the port in
// every cycle where gnt[i]=1 and may strobe wr_en_in in any of those cycles.
// Dropping req ends the burst; gnt falls after the edge that samples req=0.
// A burst is also ended by the arbiter after MAX_HOLD granted cycles, after
// which the requester must wait its round-robin turn again. Strobes issued
// while gnt[i]=0 are discarded and flagged on conflict.

module fb_write_arbiter #(
  parameter int              NREQ       = 3,
  parameter int              AW         = 10,
  parameter int              DW         = 32,
  parameter int              MAX_HOLD   = 64,
  parameter int              CLEAR_BASE = 0,
  parameter int              CLEAR_LEN  = 512,
  parameter logic [DW-1:0]   CLEAR_DATA = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  input  logic [NREQ-1:0]      wr_en_in,
  input  logic [NREQ*AW-1:0]   wr_addr_in,
  input  logic [NREQ*DW-1:0]   wr_data_in,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_data,
  output logic                 conflict
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int CW = $clog2(CLEAR_LEN + 1);

  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [AW-1:0] BASE_W   = AW'(CLEAR_BASE);
  localparam logic [CW-1:0] LEN_W    = CW'(CLEAR_LEN);
  localparam logic [HW-1:0] HOLD_W   = HW'(MAX_HOLD);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] clr_cnt;
  logic          clear_pending;

  // Round-robin pick: first set req bit searching upward from last+1 with wrap.
  int            cand;
  logic [IW-1:0] cand_idx;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  always_comb begin
    cand       = 0;
    cand_idx   = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand     = (int'(last) + off) % NREQ;
      cand_idx = IW'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Write mux driven straight from the one-hot grant register.
  logic          fwd;
  logic          granted_req;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  always_comb begin
    fwd         = |(wr_en_in & gnt);
    granted_req = |(req & gnt);
    sel_addr    = '0;
    sel_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = wr_addr_in[i*AW +: AW];
        sel_data = wr_data_in[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      last          <= LAST_RST;
      hold_cnt      <= '0;
      clr_cnt       <= '0;
      clear_pending <= 1'b0;
      gnt           <= '0;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      conflict      <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      clear_done <= 1'b0;

      // Strobes from anyone not holding the grant are dropped; gnt is all
      // zero during a clear, so writers poking the port then are flagged too.
      if (|(wr_en_in & ~gnt)) conflict <= 1'b1;

      if (clear_start && state != S_CLEAR) clear_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          // A pending clear outranks every req, but only from IDLE, so it
          // never cuts into a running burst.
          if (clear_pending) begin
            state      <= S_CLEAR;
            clear_busy <= 1'b1;
            clr_cnt    <= '0;
          end else if (pick_valid) begin
            state    <= S_GRANT;
            gnt      <= ONE_HOT0 << pick_idx;
            last     <= pick_idx;
            hold_cnt <= HW'(1);
          end
        end

        S_GRANT: begin
          if (fwd) begin
            mem_we   <= 1'b1;
            mem_addr <= sel_addr;
            mem_data <= sel_data;
          end
          // hold_cnt counts granted cycles already completed at this edge.
          if (!granted_req || hold_cnt == HOLD_W) begin
            state <= S_IDLE;
            gnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_CLEAR: begin
          // One extra cycle after the last write retires the clear, so
          // clear_done lands one cycle after the final write.
          if (clr_cnt != LEN_W) begin
            mem_we   <= 1'b1;
            mem_addr <= BASE_W + AW'(clr_cnt);
            mem_data <= CLEAR_DATA;
            clr_cnt  <= clr_cnt + 1'b1;
          end else begin
            state         <= S_IDLE;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b1;
            clear_pending <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single write port of the LED-matrix column memory between up to NREQ writer blocks (digit writer, text/scroll writers, etc.) using round-robin burst grants. It also contains a clear engine that fills a memory region with a constant. It sits between the writer blocks and the column RAM write port, and all RAM writes pass through it.

## Interface
- NREQ, 3, number of requesters (2..8)
- AW, 10, memory address width
- DW, 32, memory data width (one column word)
- MAX_HOLD, 64, maximum consecutive cycles a single grant may last
- CLEAR_BASE, 0, first address written by the clear engine
- CLEAR_LEN, 512, number of words written per clear (1..2^AW)
- CLEAR_DATA, 0, word written by the clear engine
- clk  in  1  system clock; one clock domain only
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester access request; held high for the whole burst
- gnt  out  NREQ  one-hot grant (all zero when no grant)
- wr_en_in  in  NREQ  per-requester write strobe
- wr_addr_in  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW]
- wr_data_in  in  NREQ*DW  flattened data; requester i uses bits [i*DW +: DW]
- clear_start  in  1  one-cycle pulse that requests a clear
- clear_busy  out  1  high while the clear engine owns the port
- clear_done  out  1  one-cycle pulse after the last clear write
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM write address
- mem_data  out  DW  RAM write data
- conflict  out  1  sticky error flag; set when a non-granted requester asserts wr_en_in

## Operation
- States: IDLE, GRANT, CLEAR.
- **IDLE**
  - If clear_pending=1, go to CLEAR.
  - Otherwise, if any req bit is set, grant the first set bit searching from (last+1) mod NREQ upward with wrap, then go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - gnt[g]=1 for granted index g; record last=g.
  - Leave to IDLE when req[g]=0 is sampled, or when the grant has lasted MAX_HOLD cycles.
  - A requester still asserting req after a forced release is eligible again, but only in round-robin order.
- **CLEAR**
  - Internal counter runs 0..CLEAR_LEN-1.
  - Each cycle writes CLEAR_DATA to CLEAR_BASE+count; the address wraps modulo 2^AW.
  - After the last write: return to IDLE, clear clear_pending, and pulse clear_done.
- **Clear requests**
  - clear_start sets clear_pending in any state except CLEAR; it is ignored during CLEAR.
  - A clear never pre-empts an active grant. It wins over every pending req at the next IDLE.
- **Write forwarding**
  - A write is forwarded only when gnt[i]=1 and wr_en_in[i]=1 in the same cycle.
  - wr_en_in from any other requester is dropped and sets conflict.
  - The clear engine's own writes never set conflict.
- **Reset**: state=IDLE, last=NREQ-1 (so requester 0 has first priority), clear_pending=0, and every output is 0 (gnt, mem_we, mem_addr, mem_data, clear_busy, clear_done, conflict).
- **rst mid-burst or mid-clear**: the operation is abandoned at once. No further writes are issued, and clear_done is not pulsed.

## Timing
- All outputs are registered.
- **Grant latency**: req sampled at edge k in IDLE → gnt visible after edge k.
- **Write latency**: wr_en_in/addr/data sampled at edge k while granted → mem_we/mem_addr/mem_data visible after edge k, for exactly one cycle per strobe.
- mem_we=0 in every cycle with no forwarded or clear write. mem_addr and mem_data hold their last values when mem_we=0.
- **Release**: req[g]=0 sampled at edge m → gnt=0 after edge m.
  - The earliest next grant is after edge m+1, giving one mandatory idle cycle between grants.
  - A MAX_HOLD forced release leaves gnt low for at least one cycle.
- **Clear**
  - IDLE with clear_pending at edge j → clear_busy=1 after edge j.
  - The first clear write is visible after edge j+1.
  - The last clear write is visible after edge j+CLEAR_LEN.
  - clear_done=1 and clear_busy=0 after edge j+CLEAR_LEN+1.
- **Simultaneous events**: clear_start and req in the same IDLE cycle → the req is granted first, and the clear follows at the next IDLE.

## Test plan
- **Reset defaults**: rst high for 2 cycles → every output is 0. Then req=3'b111 → gnt=3'b001 one cycle later.
- **Round-robin rotation**: req=3'b111 held, each requester drops req after 4 granted cycles → grant order 0,1,2,0 with exactly one gnt=0 cycle between grants.
- **Write path**: requester 1 granted, drives wr_en/addr=172/data=32'hA5A5_0001 for 3 cycles → mem_we high for 3 consecutive cycles, one cycle later, with matching addr/data.
- **Starvation limit and conflict flag**
  - MAX_HOLD=8, req[0] held high with req[2] pending → gnt[0] lasts exactly 8 cycles, then gnt[2] follows.
  - A wr_en_in[2] pulse during gnt[0] → no write reaches mem_we, and conflict=1 until rst.
- **Clear during a grant**
  - CLEAR_LEN=16, clear_start while requester 0 is mid-burst → the burst completes.
  - Then 16 writes of CLEAR_DATA to addresses 0..15, one per cycle, then a one-cycle clear_done pulse with no grants during the clear.
- **rst during a clear**: assert rst at clear write 5 → mem_we=0 the next cycle, no clear_done, and clear_busy=0.
